uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive buffer placed between the UART receiver (`uart_rx`) and the UART MMIO register block. It acknowledges every byte the receiver presents and stores up to DEPTH bytes. Its read side has the same valid/read-ack protocol the receiver exposes, so the MMIO block's RX data and status reads work unchanged with the FIFO in place. Software can then absorb bursts at 115200 baud without losing characters between polls.

## Interface

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not to be overridden).

Ports:
- i_clk  in  1  single system clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_rx_data  in  8  byte from the receiver.
- i_rx_valid  in  1  receiver holds a valid byte (level, held until acked).
- o_rx_ack  out  1  combinational; equals i_rx_valid; consumes the receiver's byte this cycle.
- o_data  out  8  head-of-FIFO byte; 8'h00 when empty.
- o_valid  out  1  FIFO non-empty.
- i_read_ack  in  1  pop the head this cycle (combinational from the MMIO read decode).
- o_count  out  PTR_W+1  current occupancy, 0..DEPTH.
- o_full  out  1  o_count == DEPTH.
- o_overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- i_clr_overrun  in  1  clears o_overrun.

## Operation

- Storage: DEPTH×8 register array, wr_ptr and rd_ptr of PTR_W bits, and a count register of PTR_W+1 bits. Pointers wrap modulo DEPTH naturally.
- push = i_rx_valid. pop = i_read_ack && o_valid.
- accept = push && (!o_full || pop).
- On accept:
  - write mem[wr_ptr] and increment wr_ptr.
- On pop:
  - increment rd_ptr.
- Count update:
  - count += accept − pop.
- Drop: push && o_full && !pop.
  - The byte is acked and discarded; wr_ptr and count are unchanged.
  - o_overrun is set on the next edge.
- o_overrun update:
  - Set on any drop.
  - Otherwise cleared when i_clr_overrun is high.
  - Set has priority over clear in the same cycle.
- i_read_ack while empty is ignored: no pointer movement and no underflow.
- Read data is combinational: o_data = o_valid ? mem[rd_ptr] : 8'h00.
- The memory array is not reset; stale contents are never visible because of the empty gating.

## Timing

- Reset values:
  - o_valid=0, o_data=8'h00, o_count=0, o_full=0, o_overrun=0.
  - wr_ptr=rd_ptr=0.
  - o_rx_ack follows i_rx_valid even during reset; the byte is discarded and overrun is not set.
- Reset mid-operation discards all stored bytes on that edge.
- Write-to-read latency: a byte acked in cycle N appears on o_data/o_valid in cycle N+1.
- Read latency is zero: o_data is valid in the same cycle o_valid is high, and the popped byte is replaced at N+1.
- Simultaneous push+pop:
  - When empty: the pop is ignored and the push lands; count goes 0 to 1.
  - When full: both are performed; count stays at DEPTH and no overrun occurs.
  - When partially full: count is unchanged; the read is at rd_ptr and the write is at wr_ptr.
- Wrap-around:
  - wr_ptr DEPTH−1 to 0 and rd_ptr DEPTH−1 to 0 need no special case.
  - Full vs empty is distinguished by count, not by the pointers.
- o_full and o_count are registered-state derived, with no combinational path from the inputs.
- o_rx_ack is the only combinational input-to-output path besides o_data/o_valid gating.

## Structure

- Shared package uart_pkg: UART_DATA_W = 8, plus a uart_status_t bit layout {overrun, full, tx_busy, rx_valid} for the MMIO status register to adopt.
- DEPTH stays a module parameter.
- No sub-module: storage, pointers and flags are small enough to sit inline.
- The MMIO block instantiates uart_rx → uart_rx_fifo and routes its read_ack to i_read_ack.

## Test plan

- Reset, then idle: o_valid=0, o_data=00, o_count=0, o_overrun=0. A lone i_read_ack pulse leaves all outputs unchanged.
- Push 0x41, 0x42, 0x43 one cycle apart, no reads → o_count=3 and o_data=41. Three single-cycle i_read_ack pulses return 41, 42, 43, then o_valid=0.
- Push 16 bytes 0x00..0x0F → o_full=1. A 17th push of 0xAA → o_rx_ack=1, o_overrun=1, count=16. Draining returns 00..0F; 0xAA is never seen.
- With full FIFO, assert push 0x55 and i_read_ack in the same cycle → no overrun, count stays 16. After draining, 0x55 is the last byte read.
- Push while empty with i_read_ack high → count becomes 1 and o_data=pushed byte the next cycle. Then i_clr_overrun and a drop in the same cycle → o_overrun=1.
- Run 40 interleaved push/pop cycles to wrap both pointers twice → output byte order matches input order. Then assert i_rst with 5 bytes stored → o_count=0 and o_valid=0 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//
// UART_DATA_W   : width of one UART character.
// uart_status_t : bit layout of the MMIO status register,
//                 {overrun, full, tx_busy, rx_valid}. The MSB is listed first.
// make_status() : assembles a status word from its individual flags.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic overrun;
        logic full;
        logic tx_busy;
        logic rx_valid;
    } uart_status_t;

    function automatic uart_status_t make_status(
        input logic overrun,
        input logic full,
        input logic tx_busy,
        input logic rx_valid
    );
        uart_status_t s;
        s.overrun  = overrun;
        s.full     = full;
        s.tx_busy  = tx_busy;
        s.rx_valid = rx_valid;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart_rx and the UART MMIO register block.
//
// Every byte the receiver presents is acked in the same cycle. A byte is
// stored unless the FIFO is full and no pop happens in that cycle. A byte
// lost this way sets a sticky overrun flag. The read side uses the same
// valid/read-ack protocol as the receiver, so the MMIO block can use either.
//
// Ports
//   i_clk          system clock; all state changes on the rising edge
//   i_rst          synchronous, active-high reset
//   i_rx_data      byte from the receiver
//   i_rx_valid     receiver holds a byte (level until acked)
//   o_rx_ack       receiver byte consumed this cycle (equals i_rx_valid)
//   o_data         head-of-FIFO byte, 8'h00 while empty
//   o_valid        FIFO non-empty
//   i_read_ack     pop the head this cycle
//   o_count        occupancy, 0..DEPTH
//   o_full         o_count == DEPTH
//   o_overrun      sticky, set when a byte was dropped on a full FIFO
//   i_clr_overrun  clears o_overrun (a same-cycle drop wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [UART_DATA_W-1:0] i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_ack,
    output logic [UART_DATA_W-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_read_ack,
    output logic [PTR_W:0]         o_count,
    output logic                   o_full,
    output logic                   o_overrun,
    input  logic                   i_clr_overrun
);

    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic                   overrun;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic accept;
    logic drop;

    // Full and empty come from the count only. The pointers are equal in both cases.
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    assign push = i_rx_valid;
    assign pop  = i_read_ack && !empty;

    // A full FIFO can still take a byte when the head is popped in the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // The receiver is acked whether or not the byte is kept. This applies during reset as well.
    assign o_rx_ack = i_rx_valid;

    // The storage array has no reset. The empty gating on o_data hides stale entries.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            mem[wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap without extra logic.
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign o_valid   = !empty;
    assign o_data    = empty ? '0 : mem[rd_ptr];
    assign o_count   = count;
    assign o_full    = full;
    assign o_overrun = overrun;

endmodule
